// File: rtl/reg_file_rename_pkg.sv
// Shared widths and null/boolean constants for the rename register file.
// Imported by the RTL and the bench so both agree on port widths.
package reg_file_rename_pkg;
  localparam int RLEN = 32;  // register data width
  localparam int RIDX = 5;   // architectural register index width
  localparam int RBID = 4;   // ROB tag width

  localparam logic [RLEN-1:0] null32 = 32'd0;
  localparam logic [RBID-1:0] null4  = 4'd0;
  localparam logic [RIDX-1:0] null5  = 5'd0;
  localparam logic            True   = 1'b1;
  localparam logic            False  = 1'b0;
endpackage

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register ROB rename tags.
// Reads return the committed value or the in-flight producer tag, with a commit bypass.
module reg_file_rename
  import reg_file_rename_pkg::*;
#(
  parameter int REG_NUM   = 32,
  parameter int ROB_IDX_W = RBID,
  parameter int XLEN      = RLEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 jp_wrong,
  input  logic [RIDX-1:0]      rs1,
  input  logic [RIDX-1:0]      rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [XLEN-1:0]      rs1_val,
  output logic [XLEN-1:0]      rs2_val,
  output logic [ROB_IDX_W-1:0] rs1_idx,
  output logic [ROB_IDX_W-1:0] rs2_idx,
  input  logic                 upd_flag,
  input  logic [ROB_IDX_W-1:0] upd_idx,
  input  logic [RIDX-1:0]      upd_rd,
  input  logic                 write_flag,
  input  logic [ROB_IDX_W-1:0] write_idx,
  input  logic [RIDX-1:0]      write_rd,
  input  logic [XLEN-1:0]      new_val
);

  localparam int RDW = 1 + ROB_IDX_W + XLEN;

  logic [XLEN-1:0]      val_q [REG_NUM];
  logic [XLEN-1:0]      val_d [REG_NUM];
  logic [ROB_IDX_W-1:0] tag_q [REG_NUM];
  logic [ROB_IDX_W-1:0] tag_d [REG_NUM];
  logic [REG_NUM-1:0]   busy_q;
  logic [REG_NUM-1:0]   busy_d;
  logic [RDW-1:0]       rd1_s;
  logic [RDW-1:0]       rd2_s;

  // Packs {busy, tag, val}; a matching commit this cycle is forwarded as not-busy.
  function automatic logic [RDW-1:0] read_port(input logic [RIDX-1:0] rs);
    logic [RDW-1:0] r;
    r = '0;
    if (rs == null5) begin
      r = '0;
    end else if (write_flag && (write_rd == rs) && busy_q[rs] && (tag_q[rs] == write_idx)) begin
      r = {False, {ROB_IDX_W{1'b0}}, new_val};
    end else if (busy_q[rs]) begin
      r = {True, tag_q[rs], {XLEN{1'b0}}};
    end else begin
      r = {False, {ROB_IDX_W{1'b0}}, val_q[rs]};
    end
    return r;
  endfunction

  // Combinational read ports
  always_comb begin
    rd1_s = read_port(rs1);
    rd2_s = read_port(rs2);
    {rs1_busy, rs1_idx, rs1_val} = rd1_s;
    {rs2_busy, rs2_idx, rs2_val} = rd2_s;
  end

  // Next-state: flush wipes renames; otherwise commit, then rename (rename wins on same rd)
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (jp_wrong) begin
      busy_d = '0;
      for (int i = 0; i < REG_NUM; i++) begin
        tag_d[i] = null4;
      end
    end else begin
      if (write_flag && (write_rd != null5)) begin
        val_d[write_rd] = new_val;
        if ((tag_q[write_rd] == write_idx) && !(upd_flag && (upd_rd == write_rd))) begin
          busy_d[write_rd] = False;
        end else begin
          busy_d[write_rd] = busy_q[write_rd];
        end
      end else begin
        val_d = val_q;
      end
      if (upd_flag && (upd_rd != null5)) begin
        busy_d[upd_rd] = True;
        tag_d[upd_rd]  = upd_idx;
      end else begin
        tag_d = tag_d;
      end
    end
  end

  // State registers; rdy low freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i] <= null32;
        tag_q[i] <= null4;
      end
    end else if (rdy) begin
      busy_q <= busy_d;
      val_q  <= val_d;
      tag_q  <= tag_d;
    end
  end

endmodule
